lcd_nibble_receiver: RTL and testbench

- Synthesizable responder for the 4-bit Spartan-3E character-LCD write bus, i.e. the LCD-side end of the link driven by the instruction transmitter.
- Watches LCD_RS, LCD_RW, LCD_E and SF_D, and pairs upper/lower nibble strobes into 10-bit words {RS, RW, D[7:0]}.
- Checks every transfer against the controller timing contract (setup, E pulse width, inter-nibble gap, inter-command gap).
- Serves as the bus monitor in transmitter benches and as an on-chip loopback checker; shares the transmitter's 50 MHz clock, so no synchronizers.

---
 rtl/lcd_timing_pkg.sv | 33 +++
 rtl/lcd_sat_counter.sv | 24 ++
 rtl/lcd_nibble_receiver.sv | 157 +++++++++++++++
 tb/tb_lcd_nibble_receiver.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared timing defaults, FSM encoding and error-bit layout for the
// Spartan-3E character-LCD 4-bit write bus.
package lcd_timing_pkg;

  localparam int DEF_SETUP_MIN   = 2;
  localparam int DEF_E_HIGH_MIN  = 12;
  localparam int DEF_NIB_GAP_MIN = 50;
  localparam int DEF_CMD_GAP_MIN = 2000;
  localparam int DEF_CNT_W       = 12;

  typedef enum logic [1:0] {
    WAIT_UP = 2'd0,
    UP_HIGH = 2'd1,
    WAIT_LO = 2'd2,
    LO_HIGH = 2'd3
  } rx_state_t;

  localparam int ERR_W       = 6;
  localparam int ERR_SETUP   = 0;
  localparam int ERR_E_SHORT = 1;
  localparam int ERR_NIB_GAP = 2;
  localparam int ERR_CMD_GAP = 3;
  localparam int ERR_RSRW    = 4;
  localparam int ERR_BUS_CHG = 5;

  // stab_cnt and gap_cnt are cleared in the event cycle itself, so the
  // elapsed span from that event to the current cycle is count + 1.
  function automatic logic span_short(input logic [31:0] cnt,
                                      input logic [31:0] min_cycles);
    return (cnt + 32'd1) < min_cycles;
  endfunction

endpackage

// File: rtl/lcd_sat_counter.sv
// Saturating up-counter with synchronous clear and enable; the reset value
// is selectable so idle-time counters can start out "long ago".
module lcd_sat_counter #(
  parameter int CNT_W      = 12,
  parameter bit RESET_ONES = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {CNT_W{RESET_ONES}};
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lcd_nibble_receiver.sv
// LCD-side monitor for the 4-bit write bus: pairs nibble strobes into
// {RS, RW, D[7:0]} words and checks every transfer against the timing contract.
module lcd_nibble_receiver #(
  parameter int SETUP_MIN   = lcd_timing_pkg::DEF_SETUP_MIN,
  parameter int E_HIGH_MIN  = lcd_timing_pkg::DEF_E_HIGH_MIN,
  parameter int NIB_GAP_MIN = lcd_timing_pkg::DEF_NIB_GAP_MIN,
  parameter int CMD_GAP_MIN = lcd_timing_pkg::DEF_CMD_GAP_MIN,
  parameter int CNT_W       = lcd_timing_pkg::DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_E,
  input  logic [3:0] SF_D,
  output logic [9:0] db,
  output logic       db_valid,
  output logic       word_err,
  output logic [5:0] err
);

  import lcd_timing_pkg::*;

  logic             e_q;
  logic [5:0]       bus_q;
  logic [5:0]       bus;
  logic             rise;
  logic             fall;
  logic             bus_chg;
  logic [CNT_W-1:0] stab_cnt;
  logic [CNT_W-1:0] e_cnt;
  logic [CNT_W-1:0] gap_cnt;

  rx_state_t        state;
  logic [5:0]       up_q;
  logic [ERR_W-1:0] word_acc;
  logic [ERR_W-1:0] viol;
  logic             setup_bad;
  logic             e_short;
  logic             in_high;

  assign bus     = {LCD_RS, LCD_RW, SF_D};
  assign rise    = LCD_E & ~e_q;
  assign fall    = ~LCD_E & e_q;
  assign bus_chg = (bus != bus_q);
  assign in_high = (state == UP_HIGH) || (state == LO_HIGH);

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q   <= 1'b0;
      bus_q <= '0;
    end else begin
      e_q   <= LCD_E;
      bus_q <= bus;
    end
  end

  lcd_sat_counter #(.CNT_W(CNT_W), .RESET_ONES(1'b1)) u_stab_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (bus_chg),
    .en    (1'b1),
    .count (stab_cnt)
  );

  lcd_sat_counter #(.CNT_W(CNT_W), .RESET_ONES(1'b0)) u_e_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (~LCD_E),
    .en    (LCD_E),
    .count (e_cnt)
  );

  lcd_sat_counter #(.CNT_W(CNT_W), .RESET_ONES(1'b1)) u_gap_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (fall),
    .en    (1'b1),
    .count (gap_cnt)
  );

  // A bus change in the rise cycle itself means zero setup time.
  always_comb begin
    viol      = '0;
    setup_bad = bus_chg || span_short(32'(stab_cnt), 32'(SETUP_MIN));
    e_short   = 32'(e_cnt) < 32'(E_HIGH_MIN);
    case (state)
      WAIT_UP: begin
        if (rise) begin
          viol[ERR_SETUP]   = setup_bad;
          viol[ERR_CMD_GAP] = span_short(32'(gap_cnt), 32'(CMD_GAP_MIN));
        end
      end
      UP_HIGH: begin
        if (fall) viol[ERR_E_SHORT] = e_short;
      end
      WAIT_LO: begin
        if (rise) begin
          viol[ERR_SETUP]   = setup_bad;
          viol[ERR_NIB_GAP] = span_short(32'(gap_cnt), 32'(NIB_GAP_MIN));
        end
      end
      LO_HIGH: begin
        if (fall) begin
          viol[ERR_E_SHORT] = e_short;
          viol[ERR_RSRW]    = (bus_q[5:4] != up_q[5:4]);
        end
      end
      default: ;
    endcase
    if (in_high && LCD_E && bus_chg) viol[ERR_BUS_CHG] = 1'b1;
  end

  // Nibbles are taken from bus_q at the fall, i.e. the last E-high sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WAIT_UP;
      up_q     <= '0;
      word_acc <= '0;
      db       <= '0;
      db_valid <= 1'b0;
      word_err <= 1'b0;
      err      <= '0;
    end else begin
      db_valid <= 1'b0;
      err      <= err | viol;
      word_acc <= word_acc | viol;
      case (state)
        WAIT_UP: begin
          if (rise) begin
            word_acc <= viol;
            state    <= UP_HIGH;
          end
        end
        UP_HIGH: begin
          if (fall) begin
            up_q  <= bus_q;
            state <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (rise) state <= LO_HIGH;
        end
        LO_HIGH: begin
          if (fall) begin
            db       <= {up_q[5:4], up_q[3:0], bus_q[3:0]};
            db_valid <= 1'b1;
            word_err <= |(word_acc | viol);
            state    <= WAIT_UP;
          end
        end
        default: state <= WAIT_UP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// Directed bench for lcd_nibble_receiver: table of timed words plus
// hand-built sequences for bus glitches and mid-word reset.
module tb_lcd_nibble_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_E;
  logic [3:0] SF_D;
  logic [9:0] db;
  logic       db_valid;
  logic       word_err;
  logic [5:0] err;

  int tests     = 0;
  int failures  = 0;
  int valid_cnt = 0;
  int valid_base = 0;
  int cyc       = 0;
  int fall_set  = 0;
  int upper_fall = 0;

  typedef struct {
    logic [9:0] word;
    int         cmd_gap;
    int         setup;
    int         e_up;
    int         nib_gap;
    int         e_lo;
    logic       exp_werr;
    logic [5:0] exp_err;
  } vec_t;

  vec_t vecs[8];

  lcd_nibble_receiver dut (
    .clk      (clk),
    .reset    (reset),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW),
    .LCD_E    (LCD_E),
    .SF_D     (SF_D),
    .db       (db),
    .db_valid (db_valid),
    .word_err (word_err),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (db_valid) valid_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_val(input string name, input logic [9:0] actual,
                           input logic [9:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic send_upper(input logic [9:0] w, input int setup, input int e_up);
    LCD_RS = w[9];
    LCD_RW = w[8];
    SF_D   = w[7:4];
    repeat (setup) tick();
    LCD_E = 1'b1;
    repeat (e_up) tick();
    LCD_E = 1'b0;
    upper_fall = cyc;
  endtask

  task automatic send_lower(input logic [9:0] w, input int nib_gap, input int e_lo);
    tick();
    SF_D = w[3:0];
    while (cyc - upper_fall < nib_gap) tick();
    LCD_E = 1'b1;
    repeat (e_lo) tick();
    LCD_E = 1'b0;
    fall_set = cyc;
  endtask

  task automatic wait_cmd_gap(input int cmd_gap, input int setup);
    while (cyc - fall_set < cmd_gap - setup) tick();
  endtask

  task automatic apply_stimulus(input vec_t v);
    valid_base = valid_cnt;
    wait_cmd_gap(v.cmd_gap, v.setup);
    send_upper(v.word, v.setup, v.e_up);
    send_lower(v.word, v.nib_gap, v.e_lo);
  endtask

  task automatic check_output(input string name, input logic [9:0] exp_db,
                              input logic exp_werr, input logic [5:0] exp_err);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      tick();
      @(negedge clk);
      if (valid_cnt != valid_base) found = 1'b1;
    end
    check_val({name, " db_valid seen"}, {9'd0, found}, 10'd1);
    if (found) begin
      check_val({name, " db"}, db, exp_db);
      check_val({name, " word_err"}, {9'd0, word_err}, {9'd0, exp_werr});
      check_val({name, " err"}, {4'd0, err}, {4'd0, exp_err});
      tick();
      @(negedge clk);
      check_val({name, " db_valid width"}, {9'd0, db_valid}, 10'd0);
      check_val({name, " pulse count"}, 10'(valid_cnt - valid_base), 10'd1);
    end
  endtask

  initial begin
    vecs[0] = '{10'h0A5,   10, 2, 12, 50, 12, 1'b0, 6'b000000};
    vecs[1] = '{10'h0F0, 2500, 2, 12, 50, 12, 1'b0, 6'b000000};
    vecs[2] = '{10'h3C3, 2000, 2, 12, 50, 12, 1'b0, 6'b000000};
    vecs[3] = '{10'h2C3, 2500, 2,  8, 50, 12, 1'b1, 6'b000010};
    vecs[4] = '{10'h15A, 2500, 2, 12, 30, 12, 1'b1, 6'b000110};
    vecs[5] = '{10'h0FF, 1000, 2, 12, 50, 12, 1'b1, 6'b001110};
    vecs[6] = '{10'h033, 2500, 1, 12, 50, 12, 1'b1, 6'b001111};
    vecs[7] = '{10'h1E1, 2500, 2, 12, 50, 11, 1'b1, 6'b001111};

    reset  = 1'b1;
    LCD_RS = 1'b0;
    LCD_RW = 1'b0;
    LCD_E  = 1'b0;
    SF_D   = 4'h0;
    repeat (3) tick();
    @(negedge clk);
    check_val("reset db", db, 10'd0);
    check_val("reset db_valid", {9'd0, db_valid}, 10'd0);
    check_val("reset word_err", {9'd0, word_err}, 10'd0);
    check_val("reset err", {4'd0, err}, 10'd0);
    reset = 1'b0;
    fall_set = cyc;

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d", i), vecs[i].word, vecs[i].exp_werr, vecs[i].exp_err);
    end

    // RS flips mid upper strobe, then flips back before the lower nibble.
    valid_base = valid_cnt;
    wait_cmd_gap(2500, 2);
    LCD_RS = 1'b0;
    LCD_RW = 1'b0;
    SF_D   = 4'h6;
    repeat (2) tick();
    LCD_E = 1'b1;
    repeat (5) tick();
    LCD_RS = 1'b1;
    repeat (7) tick();
    LCD_E = 1'b0;
    upper_fall = cyc;
    tick();
    LCD_RS = 1'b0;
    SF_D   = 4'h9;
    while (cyc - upper_fall < 50) tick();
    LCD_E = 1'b1;
    repeat (12) tick();
    LCD_E = 1'b0;
    fall_set = cyc;
    check_output("rs_toggle", 10'h269, 1'b1, 6'b111111);

    // Reset while waiting for the lower nibble discards the partial word.
    valid_base = valid_cnt;
    wait_cmd_gap(2500, 2);
    send_upper(10'h2B7, 2, 12);
    repeat (10) tick();
    reset  = 1'b1;
    LCD_RS = 1'b0;
    LCD_RW = 1'b0;
    SF_D   = 4'h0;
    repeat (3) tick();
    @(negedge clk);
    check_val("midword reset no valid", 10'(valid_cnt - valid_base), 10'd0);
    check_val("midword reset err", {4'd0, err}, 10'd0);
    check_val("midword reset db", db, 10'd0);
    reset = 1'b0;
    fall_set = cyc;
    apply_stimulus('{10'h128, 10, 2, 12, 50, 12, 1'b0, 6'b000000});
    check_output("after_reset", 10'h128, 1'b0, 6'b000000);

    // E held high well past counter saturation must not flag a short pulse.
    apply_stimulus('{10'h2D4, 2500, 2, 4200, 50, 12, 1'b0, 6'b000000});
    check_output("e_saturate", 10'h2D4, 1'b0, 6'b000000);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
